ysyx_23060203_axi_rw_sched: RTL and testbench

//  Single-master AXI4-Lite scheduler. Sits between the core-side read port (after IFU/LSU read arbitration)
//  and the LSU write port on one side, and the single SoC AXI master on the other. Serialises reads and

---
 rtl/ysyx_23060203_axi_rw_sched_if.sv | 34 +++
 rtl/ysyx_23060203_axi_rw_sched.sv | 146 ++++++++++++++
 tb/tb_ysyx_23060203_axi_rw_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060203_axi_rw_sched_if.sv
// AXI4-Lite channel bundle: AR, R, AW, W, B with a fixed 32-bit data path.
// Latency: none, wires only.
// Backpressure: plain valid/ready per channel; master drives valids, slave drives readies.
interface ysyx_23060203_axi_rw_sched_if #(
  parameter int AW = 32
);
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic          rvalid;
  logic          rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic          wvalid;
  logic          wready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_23060203_axi_rw_sched.sv
// Single-master AXI4-Lite scheduler: one outstanding read or write, write priority with a read-starvation bound, sticky error capture.
// Latency: one grant cycle in IDLE, then channels pass through combinationally; 3 cycles IDLE->IDLE minimum per transaction.
// Backpressure: nothing is buffered; core readies mirror SoC readies only in the state that owns the channel.
module ysyx_23060203_axi_rw_sched #(
  parameter int STARVE_MAX = 3,
  parameter int AW         = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  ysyx_23060203_axi_rw_sched_if.slave         core,
  ysyx_23060203_axi_rw_sched_if.master        m,
  output logic                                err_valid,
  output logic [AW-1:0]                       err_addr,
  output logic                                err_is_write
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [2:0] { IDLE, RD_A, RD_D, WR_AW, WR_B } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          aw_done, w_done;
  logic [AW-1:0] addr_q;

  logic rd_pend, wr_pend;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign rd_pend = core.arvalid;
  assign wr_pend = core.awvalid & core.wvalid;

  // Handshakes are qualified by the owning state so they never fire on channels driven to 0.
  assign ar_hs = (state == RD_A)  & core.arvalid & m.arready;
  assign r_hs  = (state == RD_D)  & m.rvalid & core.rready;
  assign aw_hs = (state == WR_AW) & ~aw_done & core.awvalid & m.awready;
  assign w_hs  = (state == WR_AW) & ~w_done & core.wvalid & m.wready;
  assign b_hs  = (state == WR_B)  & m.bvalid & core.bready;

  // Next-state selection and per-state channel routing; unowned channels stay at 0.
  always_comb begin
    state_nxt    = state;
    core.arready = 1'b0;
    core.rvalid  = 1'b0;
    core.rdata   = '0;
    core.rresp   = '0;
    core.awready = 1'b0;
    core.wready  = 1'b0;
    core.bvalid  = 1'b0;
    core.bresp   = '0;
    m.arvalid    = 1'b0;
    m.araddr     = '0;
    m.rready     = 1'b0;
    m.awvalid    = 1'b0;
    m.awaddr     = '0;
    m.wvalid     = 1'b0;
    m.wdata      = '0;
    m.wstrb      = '0;
    m.bready     = 1'b0;
    case (state)
      IDLE: begin
        // Reads win only when no write is pending or writes have starved the read long enough.
        if (rd_pend && (!wr_pend || starve_cnt == STARVE_TOP)) state_nxt = RD_A;
        else if (wr_pend)                                     state_nxt = WR_AW;
      end
      RD_A: begin
        m.arvalid    = core.arvalid;
        m.araddr     = core.araddr;
        core.arready = m.arready;
        if (ar_hs) state_nxt = RD_D;
      end
      RD_D: begin
        core.rvalid = m.rvalid;
        core.rdata  = m.rdata;
        core.rresp  = m.rresp;
        m.rready    = core.rready;
        if (r_hs) state_nxt = IDLE;
      end
      WR_AW: begin
        // A completed channel goes quiet so the slave never sees a duplicate beat.
        m.awvalid    = core.awvalid & ~aw_done;
        m.awaddr     = aw_done ? '0 : core.awaddr;
        core.awready = m.awready & ~aw_done;
        m.wvalid     = core.wvalid & ~w_done;
        m.wdata      = w_done ? '0 : core.wdata;
        m.wstrb      = w_done ? '0 : core.wstrb;
        core.wready  = m.wready & ~w_done;
        if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_B;
      end
      WR_B: begin
        core.bvalid = m.bvalid;
        core.bresp  = m.bresp;
        m.bready    = core.bready;
        if (b_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Count write grants taken while a read waits; a read grant resets the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && state_nxt == RD_A) begin
      starve_cnt <= '0;
    end else if (state == IDLE && state_nxt == WR_AW && core.arvalid && starve_cnt != STARVE_TOP) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Per-channel completion flags for the write address/data phase; cleared on leaving it.
  always_ff @(posedge clock) begin
    if (reset || state_nxt != WR_AW) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Remember the address of the transaction in flight for error reporting.
  always_ff @(posedge clock) begin
    if (reset)      addr_q <= '0;
    else if (ar_hs) addr_q <= core.araddr;
    else if (aw_hs) addr_q <= core.awaddr;
  end

  // Sticky capture of the first SLVERR/DECERR response; later errors are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_is_write <= 1'b0;
    end else if (!err_valid && ((r_hs && m.rresp[1]) || (b_hs && m.bresp[1]))) begin
      err_valid    <= 1'b1;
      err_addr     <= addr_q;
      err_is_write <= b_hs;
    end
  end
endmodule

// File: tb/tb_ysyx_23060203_axi_rw_sched.sv
// Directed bench for the AXI4-Lite read/write scheduler.
// Latency: drives on negedge, samples 1-2 ns later, state changes on posedge.
// Backpressure: the bench plays both the core master and the SoC slave.
module tb_ysyx_23060203_axi_rw_sched;
  logic        clock = 1'b0;
  logic        reset;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_is_write;
  int          n_vec = 0;
  int          n_err = 0;

  ysyx_23060203_axi_rw_sched_if #(.AW(32)) core_bus ();
  ysyx_23060203_axi_rw_sched_if #(.AW(32)) soc_bus ();

  ysyx_23060203_axi_rw_sched #(.STARVE_MAX(2), .AW(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .core         (core_bus),
    .m            (soc_bus),
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_is_write (err_is_write)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          exp_cyc;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    bit          exp_err;
    logic [31:0] exp_eaddr;
    bit          exp_ewr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    core_bus.arvalid = 0; core_bus.araddr = '0; core_bus.rready = 0;
    core_bus.awvalid = 0; core_bus.awaddr = '0; core_bus.wvalid = 0;
    core_bus.wdata = '0; core_bus.wstrb = '0; core_bus.bready = 0;
    soc_bus.arready = 0; soc_bus.rvalid = 0; soc_bus.rdata = '0; soc_bus.rresp = '0;
    soc_bus.awready = 0; soc_bus.wready = 0; soc_bus.bvalid = 0; soc_bus.bresp = '0;
  endtask

  // Every DUT output must be 0 and the FSM idle.
  task automatic chk_quiet(input string tag);
    chk({tag, " handshakes"}, {core_bus.arready, core_bus.rvalid, core_bus.awready, core_bus.wready,
        core_bus.bvalid, soc_bus.arvalid, soc_bus.rready, soc_bus.awvalid, soc_bus.wvalid,
        soc_bus.bready, err_valid, err_is_write}, 32'h0);
    chk({tag, " data"}, core_bus.rdata | soc_bus.araddr | soc_bus.awaddr | soc_bus.wdata |
        {28'h0, soc_bus.wstrb} | {30'h0, core_bus.rresp} | {30'h0, core_bus.bresp} | err_addr, 32'h0);
    chk({tag, " state"}, 32'(dut.state), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One transaction against a zero-wait slave; returns what was seen on both sides.
  task automatic run_txn(input vec_t v, output int cyc, output logic [31:0] g_addr,
                         output logic [31:0] g_wdata, output logic [3:0] g_wstrb,
                         output logic [31:0] g_data, output logic [1:0] g_resp);
    bit r_pend, b_pend, drop_ar, drop_aw, drop_w, done, aw_seen, w_seen;
    r_pend = 0; b_pend = 0; drop_ar = 0; drop_aw = 0; drop_w = 0; done = 0; aw_seen = 0; w_seen = 0;
    cyc = 0; g_addr = '0; g_wdata = '0; g_wstrb = '0; g_data = '0; g_resp = '0;
    @(negedge clock);
    core_bus.rready = 1; core_bus.bready = 1;
    if (v.wr) begin
      core_bus.awvalid = 1; core_bus.awaddr = v.addr;
      core_bus.wvalid = 1; core_bus.wdata = v.data; core_bus.wstrb = v.strb;
    end else begin
      core_bus.arvalid = 1; core_bus.araddr = v.addr;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      if (i > 0) @(negedge clock);
      if (drop_ar) core_bus.arvalid = 0;
      if (drop_aw) core_bus.awvalid = 0;
      if (drop_w)  core_bus.wvalid = 0;
      soc_bus.rvalid = r_pend;
      soc_bus.rdata  = r_pend ? v.data : 32'h0;
      soc_bus.rresp  = r_pend ? v.resp : 2'b00;
      soc_bus.bvalid = b_pend;
      soc_bus.bresp  = b_pend ? v.resp : 2'b00;
      #1;
      soc_bus.arready = soc_bus.arvalid;
      soc_bus.awready = soc_bus.awvalid;
      soc_bus.wready  = soc_bus.wvalid;
      #1;
      cyc++;
      if (soc_bus.arvalid && soc_bus.arready) begin g_addr = soc_bus.araddr; r_pend = 1; end
      if (core_bus.arvalid && core_bus.arready) drop_ar = 1;
      if (soc_bus.awvalid && soc_bus.awready) begin g_addr = soc_bus.awaddr; aw_seen = 1; end
      if (core_bus.awvalid && core_bus.awready) drop_aw = 1;
      if (soc_bus.wvalid && soc_bus.wready) begin g_wdata = soc_bus.wdata; g_wstrb = soc_bus.wstrb; w_seen = 1; end
      if (core_bus.wvalid && core_bus.wready) drop_w = 1;
      if (core_bus.rvalid && core_bus.rready) begin
        g_data = core_bus.rdata; g_resp = core_bus.rresp; r_pend = 0; done = 1;
      end
      if (core_bus.bvalid && core_bus.bready) begin
        g_resp = core_bus.bresp; b_pend = 0; done = 1;
      end else if (aw_seen && w_seen) begin
        b_pend = 1;
      end
    end
    if (!done) cyc = 99;
    @(negedge clock);
    clear_inputs();
    #1;
  endtask

  initial begin
    vec_t        vt[8];
    int          cyc, nb, na, nw, ar_at;
    bit          b_pend, drop_w, drop_aw;
    logic [31:0] ga, gw, gd;
    logic [3:0]  gs;
    logic [1:0]  gr;

    vt[0] = '{rst:1, wr:0, addr:32'h8000_0000, data:32'h1234_5678, strb:4'h0, resp:2'b00, exp_cyc:3,
              exp_data:32'h1234_5678, exp_resp:2'b00, exp_err:0, exp_eaddr:32'h0, exp_ewr:0};
    vt[1] = '{rst:0, wr:1, addr:32'h0F00_0000, data:32'hA5A5_A5A5, strb:4'hF, resp:2'b00, exp_cyc:3,
              exp_data:32'hA5A5_A5A5, exp_resp:2'b00, exp_err:0, exp_eaddr:32'h0, exp_ewr:0};
    vt[2] = '{rst:0, wr:0, addr:32'h0000_0040, data:32'hDEAD_BEEF, strb:4'h0, resp:2'b01, exp_cyc:3,
              exp_data:32'hDEAD_BEEF, exp_resp:2'b01, exp_err:0, exp_eaddr:32'h0, exp_ewr:0};
    vt[3] = '{rst:0, wr:1, addr:32'h2000_0004, data:32'h0000_00FF, strb:4'h1, resp:2'b00, exp_cyc:3,
              exp_data:32'h0000_00FF, exp_resp:2'b00, exp_err:0, exp_eaddr:32'h0, exp_ewr:0};
    vt[4] = '{rst:0, wr:0, addr:32'h1000_0000, data:32'hCAFE_F00D, strb:4'h0, resp:2'b10, exp_cyc:3,
              exp_data:32'hCAFE_F00D, exp_resp:2'b10, exp_err:1, exp_eaddr:32'h1000_0000, exp_ewr:0};
    vt[5] = '{rst:0, wr:1, addr:32'h3000_0000, data:32'h0000_0001, strb:4'hF, resp:2'b11, exp_cyc:3,
              exp_data:32'h0000_0001, exp_resp:2'b11, exp_err:1, exp_eaddr:32'h1000_0000, exp_ewr:0};
    vt[6] = '{rst:0, wr:0, addr:32'h4000_0000, data:32'h0BAD_F00D, strb:4'h0, resp:2'b11, exp_cyc:3,
              exp_data:32'h0BAD_F00D, exp_resp:2'b11, exp_err:1, exp_eaddr:32'h1000_0000, exp_ewr:0};
    vt[7] = '{rst:1, wr:1, addr:32'h0A00_0010, data:32'h55AA_55AA, strb:4'hC, resp:2'b10, exp_cyc:3,
              exp_data:32'h55AA_55AA, exp_resp:2'b10, exp_err:1, exp_eaddr:32'h0A00_0010, exp_ewr:1};

    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    @(negedge clock);
    #1;
    chk_quiet("reset");
    chk("reset starve_cnt", 32'(dut.starve_cnt), 32'd0);
    reset = 1'b0;

    // Read and write pending together: write goes first.
    do_reset();
    @(negedge clock);
    core_bus.arvalid = 1; core_bus.araddr = 32'h5000_0000;
    core_bus.awvalid = 1; core_bus.awaddr = 32'h0F00_0000;
    core_bus.wvalid = 1; core_bus.wdata = 32'hA5A5_A5A5; core_bus.wstrb = 4'hF;
    core_bus.rready = 1; core_bus.bready = 1;
    soc_bus.arready = 1; soc_bus.awready = 1; soc_bus.wready = 1;
    #1;
    chk("t2 grant cycle quiet", {core_bus.arready, core_bus.awready, core_bus.wready,
        soc_bus.arvalid, soc_bus.awvalid}, 32'h0);
    @(negedge clock); #1;
    chk("t2 aw/w before ar", {soc_bus.awvalid, soc_bus.wvalid, soc_bus.arvalid}, 32'b110);
    chk("t2 awaddr", soc_bus.awaddr, 32'h0F00_0000);
    chk("t2 wdata", soc_bus.wdata, 32'hA5A5_A5A5);
    @(negedge clock);
    core_bus.awvalid = 0; core_bus.wvalid = 0; soc_bus.bvalid = 1; soc_bus.bresp = 2'b00;
    #1;
    chk("t2 b phase", {core_bus.bvalid, soc_bus.bready, soc_bus.arvalid}, 32'b110);
    @(negedge clock);
    soc_bus.bvalid = 0;
    #1;
    chk("t2 ar held after b", soc_bus.arvalid, 32'h0);
    chk("t2 starve after write", 32'(dut.starve_cnt), 32'd1);
    @(negedge clock); #1;
    chk("t2 ar granted", {soc_bus.arvalid, core_bus.arready}, 32'b11);
    chk("t2 araddr", soc_bus.araddr, 32'h5000_0000);
    @(negedge clock);
    core_bus.arvalid = 0; soc_bus.rvalid = 1; soc_bus.rdata = 32'h0000_BEEF;
    #1;
    chk("t2 rdata", core_bus.rdata, 32'h0000_BEEF);
    chk("t2 starve after read", 32'(dut.starve_cnt), 32'd0);
    @(negedge clock);
    soc_bus.rvalid = 0;
    #1;
    chk("t2 back to idle", 32'(dut.state), 32'd0);
    clear_inputs();

    // Starvation bound: with STARVE_MAX=2 exactly two writes precede the read.
    do_reset();
    @(negedge clock);
    core_bus.arvalid = 1; core_bus.araddr = 32'h6000_0000;
    core_bus.awvalid = 1; core_bus.awaddr = 32'h7000_0000;
    core_bus.wvalid = 1; core_bus.wdata = 32'h0102_0304; core_bus.wstrb = 4'hF;
    core_bus.rready = 1; core_bus.bready = 1;
    soc_bus.arready = 1; soc_bus.awready = 1; soc_bus.wready = 1;
    nb = 0; ar_at = -1; b_pend = 0;
    for (int i = 0; i < 30 && ar_at < 0; i++) begin
      if (i > 0) @(negedge clock);
      soc_bus.bvalid = b_pend;
      #1;
      if (core_bus.bvalid && core_bus.bready) begin nb++; b_pend = 0; end
      else if (soc_bus.awvalid && soc_bus.awready && soc_bus.wvalid && soc_bus.wready) b_pend = 1;
      if (soc_bus.arvalid && soc_bus.arready) ar_at = nb;
    end
    chk("t3 writes before read", 32'(ar_at), 32'd2);
    @(negedge clock);
    core_bus.arvalid = 0; core_bus.awvalid = 0; core_bus.wvalid = 0;
    soc_bus.rvalid = 1; soc_bus.rdata = 32'h0000_0003;
    #1;
    chk("t3 read data phase", 32'(dut.state), 32'd2);
    chk("t3 starve cleared", 32'(dut.starve_cnt), 32'd0);
    @(negedge clock);
    soc_bus.rvalid = 0;
    #1;
    chk("t3 idle after read", 32'(dut.state), 32'd0);
    chk("t3 starve stays 0", 32'(dut.starve_cnt), 32'd0);
    clear_inputs();

    // W accepted three cycles before AW: one W beat, one B.
    @(negedge clock);
    core_bus.awvalid = 1; core_bus.awaddr = 32'h0B00_0000;
    core_bus.wvalid = 1; core_bus.wdata = 32'h1122_3344; core_bus.wstrb = 4'hF;
    core_bus.bready = 1;
    soc_bus.wready = 1;
    na = 0; nw = 0; nb = 0; b_pend = 0; drop_w = 0; drop_aw = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clock);
      if (drop_w)  core_bus.wvalid = 0;
      if (drop_aw) core_bus.awvalid = 0;
      soc_bus.awready = (i == 4);
      soc_bus.bvalid  = b_pend;
      #1;
      if (i == 2) chk("t4 w quiet after hs", {soc_bus.wvalid, core_bus.wready, soc_bus.awvalid}, 32'b001);
      if (soc_bus.wvalid && soc_bus.wready) nw++;
      if (soc_bus.awvalid && soc_bus.awready) na++;
      if (core_bus.wvalid && core_bus.wready) drop_w = 1;
      if (core_bus.awvalid && core_bus.awready) drop_aw = 1;
      if (core_bus.bvalid && core_bus.bready) begin nb++; b_pend = 0; end
      else if (na == 1 && nw == 1 && nb == 0) b_pend = 1;
    end
    chk("t4 w beats", 32'(nw), 32'd1);
    chk("t4 aw beats", 32'(na), 32'd1);
    chk("t4 b responses", 32'(nb), 32'd1);
    chk("t4 idle", 32'(dut.state), 32'd0);
    clear_inputs();

    // Table of single transactions with a zero-wait slave.
    for (int k = 0; k < 8; k++) begin
      if (vt[k].rst) do_reset();
      run_txn(vt[k], cyc, ga, gw, gs, gd, gr);
      chk($sformatf("v%0d cycles", k), 32'(cyc), 32'(vt[k].exp_cyc));
      chk($sformatf("v%0d bus addr", k), ga, vt[k].addr);
      if (vt[k].wr) begin
        chk($sformatf("v%0d wdata", k), gw, vt[k].exp_data);
        chk($sformatf("v%0d wstrb", k), {28'h0, gs}, {28'h0, vt[k].strb});
      end else begin
        chk($sformatf("v%0d rdata", k), gd, vt[k].exp_data);
      end
      chk($sformatf("v%0d resp", k), {30'h0, gr}, {30'h0, vt[k].exp_resp});
      chk($sformatf("v%0d idle", k), 32'(dut.state), 32'd0);
      chk($sformatf("v%0d err_valid", k), {31'h0, err_valid}, {31'h0, vt[k].exp_err});
      chk($sformatf("v%0d err_addr", k), err_addr, vt[k].exp_eaddr);
      chk($sformatf("v%0d err_is_write", k), {31'h0, err_is_write}, {31'h0, vt[k].exp_ewr});
    end

    // Reset while in the read data phase with rvalid held.
    @(negedge clock);
    core_bus.arvalid = 1; core_bus.araddr = 32'h0C00_0000;
    soc_bus.arready = 1;
    @(negedge clock); #1;
    @(negedge clock);
    soc_bus.rvalid = 1; soc_bus.rdata = 32'hFFFF_0000; soc_bus.rresp = 2'b10;
    #1;
    chk("t6 in read data phase", 32'(dut.state), 32'd2);
    chk("t6 rvalid forwarded", {31'h0, core_bus.rvalid}, 32'h1);
    core_bus.rready = 1;
    core_bus.awvalid = 1; core_bus.wvalid = 1;
    soc_bus.awready = 1; soc_bus.wready = 1; soc_bus.bvalid = 1;
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk_quiet("t6 after reset");
    reset = 1'b0;
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
